fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/fetch_ctrl.sv | 119 +++++++++++
 tb/tb_fetch_ctrl.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
//  fetch_pkg
//  Shared constants and state type for the instruction-fetch controller.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int          c_INST_W       = 32;
  localparam logic [31:0] c_RESET_VECTOR = 32'hbfc0_0000;

  localparam logic [2:0] c_ST_IDLE   = 3'd0;
  localparam logic [2:0] c_ST_REQ    = 3'd1;
  localparam logic [2:0] c_ST_WAIT   = 3'd2;
  localparam logic [2:0] c_ST_HOLD   = 3'd3;
  localparam logic [2:0] c_ST_CANCEL = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE   = c_ST_IDLE,
    ST_REQ    = c_ST_REQ,
    ST_WAIT   = c_ST_WAIT,
    ST_HOLD   = c_ST_HOLD,
    ST_CANCEL = c_ST_CANCEL
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
//  fetch_ctrl
//  Single-outstanding instruction fetch FSM with a one-entry decode buffer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         pc,
  input  logic                is_exp,
  input  logic                de_allowin,
  output logic                inst_req,
  output logic [31:0]         inst_addr,
  input  logic                inst_addr_ok,
  input  logic                inst_data_ok,
  input  logic [c_INST_W-1:0] inst_rdata,
  output logic                pc_stall,
  output logic                fs_valid,
  output logic [c_INST_W-1:0] fs_inst,
  output logic [31:0]         fs_pc,
  output logic                fs_adel,
  output logic [31:0]         stall_cnt
);

  fetch_state_e        r_state;
  logic [c_INST_W-1:0] r_fs_inst;
  logic [31:0]         r_fs_pc;
  logic                r_fs_adel;
  logic [31:0]         r_stall_cnt;

  logic w_misaligned;
  logic w_counting;
  logic w_release;

  assign w_misaligned = (pc[1:0] != 2'b00);
  assign w_counting   = (r_state == ST_REQ) || (r_state == ST_WAIT) ||
                        (r_state == ST_CANCEL);
  // PC may advance only when the buffered instruction is actually consumed.
  assign w_release    = (r_state == ST_HOLD) && de_allowin && !is_exp;

  assign inst_req  = (r_state == ST_REQ) && !w_misaligned;
  assign inst_addr = pc;
  assign pc_stall  = !w_release;
  assign fs_valid  = (r_state == ST_HOLD);
  assign fs_inst   = r_fs_inst;
  assign fs_pc     = r_fs_pc;
  assign fs_adel   = r_fs_adel;
  assign stall_cnt = r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_fs_inst   <= '0;
      r_fs_pc     <= '0;
      r_fs_adel   <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_counting) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      case (r_state)
        ST_IDLE: begin
          r_state <= ST_REQ;
        end
        ST_REQ: begin
          // A misaligned PC never reaches memory; it is reported as a fault.
          if (w_misaligned) begin
            if (!is_exp) begin
              r_state   <= ST_HOLD;
              r_fs_inst <= '0;
              r_fs_pc   <= pc;
              r_fs_adel <= 1'b1;
            end
          end else if (inst_addr_ok) begin
            if (is_exp) begin
              r_state <= ST_CANCEL;
            end else begin
              r_state <= ST_WAIT;
              r_fs_pc <= pc;
            end
          end
        end
        ST_WAIT: begin
          if (inst_data_ok) begin
            if (is_exp) begin
              r_state <= ST_REQ;
            end else begin
              r_state   <= ST_HOLD;
              r_fs_inst <= inst_rdata;
              r_fs_adel <= 1'b0;
            end
          end else if (is_exp) begin
            r_state <= ST_CANCEL;
          end
        end
        ST_HOLD: begin
          if (is_exp || de_allowin) begin
            r_state <= ST_REQ;
          end
        end
        ST_CANCEL: begin
          if (inst_data_ok) begin
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
//  tb_fetch_ctrl
//  Self-checking bench: directed vectors, corner sequences, random vs model.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        is_exp;
  logic        de_allowin;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        pc_stall;
  logic        fs_valid;
  logic [31:0] fs_inst;
  logic [31:0] fs_pc;
  logic        fs_adel;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_ctrl u_dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .is_exp       (is_exp),
    .de_allowin   (de_allowin),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .pc_stall     (pc_stall),
    .fs_valid     (fs_valid),
    .fs_inst      (fs_inst),
    .fs_pc        (fs_pc),
    .fs_adel      (fs_adel),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // Transaction-level reference: what is buffered, what is in flight.
  bit          m_idle;
  bit          m_buf;
  bit          m_inflight;
  bit          m_discard;
  logic [31:0] m_inst;
  logic [31:0] m_pc;
  bit          m_adel;
  logic [31:0] m_cnt;

  function automatic bit m_issuing();
    return !m_idle && !m_buf && !m_inflight;
  endfunction

  task automatic model_reset();
    m_idle = 1; m_buf = 0; m_inflight = 0; m_discard = 0;
    m_inst = '0; m_pc = '0; m_adel = 0; m_cnt = '0;
  endtask

  task automatic model_clock();
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_issuing() || m_inflight) m_cnt = m_cnt + 32'd1;
    if (m_idle) begin
      m_idle = 0;
    end else if (m_buf) begin
      if (is_exp || de_allowin) m_buf = 0;
    end else if (m_inflight) begin
      if (inst_data_ok) begin
        if (!m_discard && !is_exp) begin
          m_buf = 1; m_inst = inst_rdata; m_adel = 0;
        end
        m_inflight = 0; m_discard = 0;
      end else if (is_exp) begin
        m_discard = 1;
      end
    end else if (pc % 4 != 0) begin
      if (!is_exp) begin
        m_buf = 1; m_inst = '0; m_pc = pc; m_adel = 1;
      end
    end else if (inst_addr_ok) begin
      m_inflight = 1;
      m_discard  = is_exp;
      if (!is_exp) m_pc = pc;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_compare();
    check("m.inst_req",  32'(inst_req),  32'(m_issuing() && pc[1:0] == 2'b00));
    check("m.inst_addr", inst_addr, pc);
    check("m.pc_stall",  32'(pc_stall),  32'(!(m_buf && de_allowin && !is_exp)));
    check("m.fs_valid",  32'(fs_valid),  32'(m_buf));
    check("m.fs_inst",   fs_inst, m_inst);
    check("m.fs_pc",     fs_pc,   m_pc);
    check("m.fs_adel",   32'(fs_adel),   32'(m_adel));
    check("m.stall_cnt", stall_cnt, m_cnt);
  endtask

  // Inputs are already applied; compare, clock, update model, return at negedge.
  task automatic step();
    #1;
    model_compare();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic drive(input bit rst_n, input logic [31:0] p, input bit exp_i,
                       input bit allow, input bit aok, input bit dok, input logic [31:0] rd);
    reset = rst_n; pc = p; is_exp = exp_i; de_allowin = allow;
    inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd;
  endtask

  task automatic do_reset();
    drive(0, 32'hbfc0_0000, 0, 0, 0, 0, 0);
    step();
    drive(1, 32'hbfc0_0000, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          rst_n, exp_i, allow, aok, dok;
    logic [31:0] p, rd;
    bit          e_req, e_stall, e_valid, e_adel;
    logic [31:0] e_inst, e_pc, e_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    // Basic fetch, then one back-to-back request.
    vecs[0] = '{1,0,0,0,0, 32'hbfc0_0000, 0,           0,1,0,0, 0, 0, 0};
    vecs[1] = '{1,0,0,1,0, 32'hbfc0_0000, 0,           1,1,0,0, 0, 0, 0};
    vecs[2] = '{1,0,0,0,1, 32'hbfc0_0000, 32'h24080001, 0,1,0,0, 0, 32'hbfc0_0000, 1};
    vecs[3] = '{1,0,1,0,0, 32'hbfc0_0000, 0,           0,0,1,0, 32'h24080001, 32'hbfc0_0000, 2};
    vecs[4] = '{1,0,0,0,0, 32'hbfc0_0004, 0,           1,1,0,0, 32'h24080001, 32'hbfc0_0000, 2};
    vecs[5] = '{1,0,0,0,1, 32'hbfc0_0004, 32'h0bad0bad, 1,1,0,0, 32'h24080001, 32'hbfc0_0000, 3};

    drive(0, 32'hbfc0_0000, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    check("reset.inst_req",  32'(inst_req), 0);
    check("reset.pc_stall",  32'(pc_stall), 1);
    check("reset.fs_valid",  32'(fs_valid), 0);
    check("reset.stall_cnt", stall_cnt, 0);
    check("reset.fs_pc",     fs_pc, 0);

    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].rst_n, vecs[i].p, vecs[i].exp_i, vecs[i].allow,
            vecs[i].aok, vecs[i].dok, vecs[i].rd);
      #1;
      check($sformatf("vec%0d.inst_req", i),  32'(inst_req), 32'(vecs[i].e_req));
      check($sformatf("vec%0d.pc_stall", i),  32'(pc_stall), 32'(vecs[i].e_stall));
      check($sformatf("vec%0d.fs_valid", i),  32'(fs_valid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.fs_adel", i),   32'(fs_adel),  32'(vecs[i].e_adel));
      check($sformatf("vec%0d.fs_inst", i),   fs_inst,   vecs[i].e_inst);
      check($sformatf("vec%0d.fs_pc", i),     fs_pc,     vecs[i].e_pc);
      check($sformatf("vec%0d.stall_cnt", i), stall_cnt, vecs[i].e_cnt);
      step();
    end

    // Decode backpressure: the buffer holds for four cycles.
    do_reset();
    step();
    drive(1, 32'hbfc0_0010, 0, 0, 1, 0, 0);                step();
    drive(1, 32'hbfc0_0010, 0, 0, 0, 1, 32'h1234_5678);    step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'hbfc0_0010, 0, 0, i == 2, 0, 0);
      #1;
      check("bp.fs_valid", 32'(fs_valid), 1);
      check("bp.fs_inst",  fs_inst, 32'h1234_5678);
      check("bp.pc_stall", 32'(pc_stall), 1);
      check("bp.inst_req", 32'(inst_req), 0);
      step();
    end

    // Exception while waiting: the late response must be discarded.
    do_reset();
    step();
    drive(1, 32'hbfc0_0020, 0, 0, 1, 0, 0);                step();
    drive(1, 32'hbfc0_0380, 1, 0, 0, 0, 0);                step();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'hbfc0_0380, 0, 0, 0, i == 2, 32'hdead_beef);
      #1;
      check("exp.cancel_valid", 32'(fs_valid), 0);
      check("exp.cancel_req",   32'(inst_req), 0);
      step();
    end
    drive(1, 32'hbfc0_0380, 0, 0, 1, 0, 0);
    #1;
    check("exp.req",  32'(inst_req), 1);
    check("exp.addr", inst_addr, 32'hbfc0_0380);
    step();
    drive(1, 32'hbfc0_0380, 0, 0, 0, 1, 32'h1111_1111);    step();
    #1;
    check("exp.fs_inst", fs_inst, 32'h1111_1111);
    check("exp.fs_pc",   fs_pc,   32'hbfc0_0380);

    // Misaligned fetch turns into an address-error entry.
    do_reset();
    step();
    drive(1, 32'hbfc0_0002, 0, 0, 1, 0, 0);
    #1;
    check("adel.inst_req", 32'(inst_req), 0);
    step();
    drive(1, 32'hbfc0_0002, 0, 0, 0, 0, 0);
    #1;
    check("adel.fs_valid", 32'(fs_valid), 1);
    check("adel.fs_adel",  32'(fs_adel), 1);
    check("adel.fs_inst",  fs_inst, 0);
    check("adel.fs_pc",    fs_pc, 32'hbfc0_0002);
    step();

    // Stall counter over a slow accept, then reset in WAIT.
    do_reset();
    step();
    for (int i = 0; i < 6; i++) begin
      drive(1, 32'hbfc0_0040, 0, 0, i == 5, 0, 0);
      step();
    end
    drive(1, 32'hbfc0_0040, 0, 0, 0, 0, 0);
    #1;
    check("cnt.wait", stall_cnt, 32'd6);
    drive(0, 32'hbfc0_0040, 0, 0, 0, 1, 32'h5555_5555);    step();
    drive(1, 32'hbfc0_0040, 0, 0, 0, 1, 32'h5555_5555);
    #1;
    check("cnt.reset_cnt",   stall_cnt, 0);
    check("cnt.reset_req",   32'(inst_req), 0);
    check("cnt.reset_stall", 32'(pc_stall), 1);
    check("cnt.reset_valid", 32'(fs_valid), 0);
    step();

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] p;
      p = {20'hbfc00, 10'($urandom), 2'b00};
      if ($urandom_range(0, 9) == 0) p[1:0] = 2'($urandom_range(1, 3));
      drive($urandom_range(0, 99) != 0, p,
            $urandom_range(0, 7) == 0, $urandom_range(0, 1),
            $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
